// File: rtl/sp_ram_responder.sv
// Single-port SRAM bank responder: byte-masked writes, fixed-latency reads, idle-cycle preload port.
// Optional SPRAM_STAT_EN builds saturating read/write counters; otherwise rd_cnt/wr_cnt are tied to 0.
module sp_ram_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cs,
  input  logic                oe,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] W_req,
  input  logic [DATA_W-1:0]   W_data,
  output logic [DATA_W-1:0]   R_data,
  input  logic                pl_valid,
  output logic                pl_ready,
  input  logic [ADDR_W-1:0]   pl_addr,
  input  logic [DATA_W-1:0]   pl_data,
  output logic                addr_err,
  output logic [31:0]         rd_cnt,
  output logic [31:0]         wr_cnt
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] pipe_data [RD_LAT];
  logic [RD_LAT-1:0] pipe_vld;

  logic             cs_acc, rd_acc, wr_acc, pl_acc;
  logic             addr_ok, pl_addr_ok;
  logic [IDX_W-1:0] idx, pl_idx;

  // Compute and preload accesses are mutually exclusive because pl_ready requires cs=0.
  assign pl_ready   = !cs && !rst;
  assign cs_acc     = cs && !rst;
  assign rd_acc     = cs_acc && (&W_req);
  assign wr_acc     = cs_acc && !(&W_req);
  assign pl_acc     = pl_valid && pl_ready;
  assign addr_ok    = {1'b0, addr} < DEPTH_EXT;
  assign pl_addr_ok = {1'b0, pl_addr} < DEPTH_EXT;
  assign idx        = addr[IDX_W-1:0];
  assign pl_idx     = pl_addr[IDX_W-1:0];

  // NOTE: the array has no reset so it maps onto SRAM macros; contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_acc && addr_ok) begin
      for (int j = 0; j < NB; j++) begin
        if (!W_req[j]) mem[idx][8*j +: 8] <= W_data[8*j +: 8];
      end
    end
    if (pl_acc && pl_addr_ok) mem[pl_idx] <= pl_data;
  end

  // NOTE: non-blocking assignments make stage 0 see the array before this edge's write,
  // and keep every pipeline stage shifting from its pre-edge value.
  always_ff @(posedge clk) begin
    if (rd_acc) pipe_data[0] <= addr_ok ? mem[idx] : '0;
    for (int k = 1; k < RD_LAT; k++) pipe_data[k] <= pipe_data[k-1];
  end

  // Only the valid bits need reset; a cleared valid discards the in-flight data.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= rd_acc && oe;
      for (int k = 1; k < RD_LAT; k++) pipe_vld[k] <= pipe_vld[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                       R_data <= '0;
    else if (pipe_vld[RD_LAT-1])   R_data <= pipe_data[RD_LAT-1];
  end

  always_ff @(posedge clk) begin
    if (rst)                                                    addr_err <= 1'b0;
    else if ((cs_acc && !addr_ok) || (pl_acc && !pl_addr_ok))   addr_err <= 1'b1;
  end

`ifdef SPRAM_STAT_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_acc && rd_cnt_q != 32'hFFFF_FFFF)              rd_cnt_q <= rd_cnt_q + 32'd1;
      if ((wr_acc || pl_acc) && wr_cnt_q != 32'hFFFF_FFFF)  wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`else
  assign rd_cnt = '0;
  assign wr_cnt = '0;
`endif

endmodule
